// File: rtl/plru_replace_ctrl_pkg.sv
// Shared constants and types for the tree-PLRU replacement controller.
// The LFSR items are only consumed when REPLACE_RANDOM_EN is defined.
package plru_replace_ctrl_pkg;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    REPL_PLRU   = 1'b0,
    REPL_RANDOM = 1'b1
  } repl_mode_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
    return {cur[LFSR_WIDTH-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/plru_replace_ctrl_tree.sv
// Combinational tree-PLRU walk and path update for a single set vector.
// Heap node layout: root is node 0, children of node n are 2n+1 (lower) and 2n+2 (upper).
module plru_tree_update
  import plru_replace_ctrl_pkg::*;
#(
  parameter  int unsigned WAY_NUM   = 4,
  localparam int unsigned WAY_WIDTH = $clog2(WAY_NUM),
  localparam int unsigned NODE_NUM  = WAY_NUM - 1
) (
  input  logic [NODE_NUM-1:0]  vec,
  input  logic [WAY_WIDTH-1:0] way,
  output logic [NODE_NUM-1:0]  upd_vec_c,
  output logic [NODE_NUM-1:0]  path_mask_c,
  output logic [WAY_WIDTH-1:0] victim_c
);

  logic [WAY_NUM-1:0] way_sel;

  // A way is the victim when every node on its path points toward it
  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    logic [WAY_WIDTH-1:0] toward;
    for (genvar l = 0; l < WAY_WIDTH; l++) begin : g_lvl
      localparam int unsigned NODE = (2 ** l - 1) + (w >> (WAY_WIDTH - l));
      localparam logic        DIR  = 1'((w >> (WAY_WIDTH - 1 - l)) & 1);
      assign toward[l] = (vec[NODE] == DIR);
    end
    assign way_sel[w] = &toward;
  end

  always_comb begin
    victim_c = '0;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (way_sel[w]) victim_c = WAY_WIDTH'(w);
    end
  end

  // Nodes on the path to the accessed way are flipped to point away from it
  for (genvar n = 0; n < NODE_NUM; n++) begin : g_node
    localparam int unsigned LVL = $clog2(n + 2) - 1;
    localparam int unsigned OFF = n - (2 ** LVL - 1);
    assign path_mask_c[n] = ((way >> (WAY_WIDTH - LVL)) == WAY_WIDTH'(OFF));
    assign upd_vec_c[n]   = path_mask_c[n] ? ~way[WAY_WIDTH-1-LVL] : vec[n];
  end

endmodule

// File: rtl/plru_replace_ctrl.sv
// Per-set tree-PLRU replacement state with multi-port hit updates and refill commit.
// Define REPLACE_RANDOM_EN to add the rand_mode input and an LFSR-driven random victim.
module plru_replace_ctrl
  import plru_replace_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH      = 256,
  parameter  int unsigned WAY_NUM    = 4,
  parameter  int unsigned READ_PORT  = 1,
  localparam int unsigned WAY_WIDTH  = $clog2(WAY_NUM),
  localparam int unsigned ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [READ_PORT-1:0]                 hit_en,
  input  logic [READ_PORT-1:0][WAY_WIDTH-1:0]  hit_way,
  input  logic [READ_PORT-1:0][ADDR_WIDTH-1:0] hit_index,
  input  logic                                 miss_en,
  input  logic [ADDR_WIDTH-1:0]                miss_index,
  input  logic                                 flush,
`ifdef REPLACE_RANDOM_EN
  input  logic                                 rand_mode,
`endif
  output logic [WAY_WIDTH-1:0]                 miss_way
);

  localparam int unsigned NODE_NUM = WAY_NUM - 1;

  logic [NODE_NUM-1:0] plru_q [DEPTH];
  logic [NODE_NUM-1:0] plru_d [DEPTH];

  logic [READ_PORT-1:0][NODE_NUM-1:0]  hit_upd;
  logic [READ_PORT-1:0][NODE_NUM-1:0]  hit_mask;
  logic [READ_PORT-1:0][WAY_WIDTH-1:0] unused_hit_victim;
  logic [NODE_NUM-1:0]                 miss_upd;
  logic [NODE_NUM-1:0]                 miss_mask;
  logic [WAY_WIDTH-1:0]                plru_victim;

  for (genvar p = 0; p < READ_PORT; p++) begin : g_hit
    plru_tree_update #(.WAY_NUM(WAY_NUM)) u_hit (
      .vec         (plru_q[hit_index[p]]),
      .way         (hit_way[p]),
      .upd_vec_c   (hit_upd[p]),
      .path_mask_c (hit_mask[p]),
      .victim_c    (unused_hit_victim[p])
    );
  end

  // Victim comes from the pre-edge vector; its path mask drives the refill update
  plru_tree_update #(.WAY_NUM(WAY_NUM)) u_miss (
    .vec         (plru_q[miss_index]),
    .way         (miss_way),
    .upd_vec_c   (miss_upd),
    .path_mask_c (miss_mask),
    .victim_c    (plru_victim)
  );

`ifdef REPLACE_RANDOM_EN
  logic [LFSR_WIDTH-1:0] lfsr_q;
  repl_mode_e            repl_mode;

  assign repl_mode = rand_mode ? REPL_RANDOM : REPL_PLRU;
  assign miss_way  = (repl_mode == REPL_RANDOM) ? lfsr_q[WAY_WIDTH-1:0] : plru_victim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (miss_en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`else
  assign miss_way = plru_victim;
`endif

  // Hits land in ascending port order, then the refill; flush wins over all
  always_comb begin
    for (int unsigned s = 0; s < DEPTH; s++) begin
      plru_d[s] = plru_q[s];
      for (int unsigned p = 0; p < READ_PORT; p++) begin
        if (hit_en[p] && (hit_index[p] == ADDR_WIDTH'(s))) begin
          plru_d[s] = (plru_d[s] & ~hit_mask[p]) | (hit_upd[p] & hit_mask[p]);
        end
      end
      if (miss_en && (miss_index == ADDR_WIDTH'(s))) begin
        plru_d[s] = (plru_d[s] & ~miss_mask) | (miss_upd & miss_mask);
      end
      if (flush) begin
        plru_d[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        plru_q[s] <= plru_d[s];
      end
    end
  end

endmodule

// File: tb/tb_plru_replace_ctrl.sv
// Self-checking bench for plru_replace_ctrl (DEPTH=256, WAY_NUM=4, READ_PORT=2).
// A 4-way PLRU model kept as per-set root/pair decisions predicts miss_way every cycle.
module tb_plru_replace_ctrl;

  logic            clk;
  logic            rst;
  logic [1:0]      hit_en;
  logic [1:0][1:0] hit_way;
  logic [1:0][7:0] hit_index;
  logic            miss_en;
  logic [7:0]      miss_index;
  logic            flush;
  logic [1:0]      miss_way;
`ifdef REPLACE_RANDOM_EN
  logic            rand_mode;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model: root choice (0 lower pair, 1 upper pair) and the choice inside each pair
  int         m_root [256];
  int         m_lo   [256];
  int         m_hi   [256];
  logic [15:0] m_lfsr;

  plru_replace_ctrl #(.DEPTH(256), .WAY_NUM(4), .READ_PORT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .hit_en     (hit_en),
    .hit_way    (hit_way),
    .hit_index  (hit_index),
    .miss_en    (miss_en),
    .miss_index (miss_index),
    .flush      (flush),
`ifdef REPLACE_RANDOM_EN
    .rand_mode  (rand_mode),
`endif
    .miss_way   (miss_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 256; s++) begin
      m_root[s] = 0;
      m_lo[s]   = 0;
      m_hi[s]   = 0;
    end
    m_lfsr = 16'hACE1;
  endfunction

  function automatic int plru_victim(input int s);
    if (m_root[s] == 0) return (m_lo[s] == 0) ? 0 : 1;
    return (m_hi[s] == 0) ? 2 : 3;
  endfunction

  function automatic int cur_victim(input int s);
`ifdef REPLACE_RANDOM_EN
    if (rand_mode) return int'(m_lfsr & 16'h0003);
`endif
    return plru_victim(s);
  endfunction

  // Accessing a way makes the tree point to the other pair and the sibling way
  function automatic void touch(input int s, input int w);
    m_root[s] = (w < 2) ? 1 : 0;
    case (w)
      0:       m_lo[s] = 1;
      1:       m_lo[s] = 0;
      2:       m_hi[s] = 1;
      default: m_hi[s] = 0;
    endcase
  endfunction

  function automatic void model_edge();
    int v;
    if (!rst) return;
    v = cur_victim(int'(miss_index));
    if (flush) begin
      for (int s = 0; s < 256; s++) begin
        m_root[s] = 0;
        m_lo[s]   = 0;
        m_hi[s]   = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (hit_en[p]) touch(int'(hit_index[p]), int'(hit_way[p]));
      end
      if (miss_en) touch(int'(miss_index), v);
    end
    if (miss_en) m_lfsr = lfsr_step(m_lfsr);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_way(input string name, input int idx, input int exp);
    miss_index = 8'(idx);
    #1;
    checks++;
    if (int'(miss_way) != exp) begin
      errors++;
      $display("FAIL %s: set %0d miss_way=%0d expected=%0d", name, idx, miss_way, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on && rst) begin
      checks++;
      if (int'(miss_way) != cur_victim(int'(miss_index))) begin
        errors++;
        $display("FAIL model_cmp t=%0t: set %0d miss_way=%0d expected=%0d",
                 $time, miss_index, miss_way, cur_victim(int'(miss_index)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    hit_en     = '0;
    hit_way    = '0;
    hit_index  = '0;
    miss_en    = 1'b0;
    miss_index = '0;
    flush      = 1'b0;
`ifdef REPLACE_RANDOM_EN
    rand_mode  = 1'b0;
`endif
    model_reset();
    #2;
    expect_way("rst_set0", 0, 0);
    expect_way("rst_set255", 255, 0);
    tick();
    rst    = 1'b1;
    chk_on = 1'b1;

    // Two hits on set 5
    hit_en = 2'b01; hit_index[0] = 8'd5; hit_way[0] = 2'd0;
    tick();
    hit_en = '0;
    expect_way("hit5_w0", 5, 2);
    expect_way("set6_idle", 6, 0);
    hit_en = 2'b01; hit_index[0] = 8'd5; hit_way[0] = 2'd2;
    tick();
    hit_en = '0;
    expect_way("hit5_w2", 5, 1);

    // Both ports on set 3: port 1 wins shared root
    hit_en = 2'b11; hit_index[0] = 8'd3; hit_way[0] = 2'd0;
    hit_index[1] = 8'd3; hit_way[1] = 2'd1;
    tick();
    hit_en = '0;
    expect_way("dual_port3", 3, 2);

    // Hit on set 7 with same-cycle flush
    hit_en = 2'b01; hit_index[0] = 8'd7; hit_way[0] = 2'd0;
    tick();
    expect_way("pre_flush7", 7, 2);
    hit_index[0] = 8'd7; hit_way[0] = 2'd3; flush = 1'b1;
    tick();
    hit_en = '0; flush = 1'b0;
    expect_way("flush7", 7, 0);
    expect_way("flush5", 5, 0);

    // Four refills on set 9 visit every way
    miss_en = 1'b1;
    expect_way("miss9_a", 9, 0);
    tick();
    expect_way("miss9_b", 9, 2);
    tick();
    expect_way("miss9_c", 9, 1);
    tick();
    expect_way("miss9_d", 9, 3);
    tick();
    miss_en = 1'b0;
    expect_way("miss9_wrap", 9, 0);

    // Disabled hit strobes carry junk way/index
    hit_en = '0; hit_index[0] = 8'd9; hit_way[0] = 2'd1;
    hit_index[1] = 8'd9; hit_way[1] = 2'd2;
    tick();
    expect_way("ignored_hit9", 9, 0);

    // Refill is applied after the hit on the same set
    hit_en = 2'b01; hit_index[0] = 8'd11; hit_way[0] = 2'd1;
    tick();
    hit_en = '0;
    expect_way("pre11", 11, 2);
    hit_en = 2'b01; hit_way[0] = 2'd0; miss_en = 1'b1;
    tick();
    hit_en = '0; miss_en = 1'b0;
    expect_way("hit_then_miss11", 11, 1);

    // Asynchronous reset mid-cycle with a pending update
    hit_en = 2'b01; hit_index[0] = 8'd12; hit_way[0] = 2'd0;
    #1;
    rst = 1'b0;
    model_reset();
    expect_way("async_rst11", 11, 0);
    tick();
    hit_en = '0;
    rst    = 1'b1;
    expect_way("no_partial12", 12, 0);

    // Random traffic on a small set window to force collisions
    for (int i = 0; i < 300; i++) begin
      hit_en       = 2'($urandom_range(0, 3));
      hit_index[0] = 8'($urandom_range(0, 15));
      hit_index[1] = 8'($urandom_range(0, 15));
      hit_way[0]   = 2'($urandom_range(0, 3));
      hit_way[1]   = 2'($urandom_range(0, 3));
      miss_en      = 1'($urandom_range(0, 1));
      miss_index   = 8'($urandom_range(0, 15));
      flush        = ($urandom_range(0, 31) == 0);
      tick();
    end
    hit_en = '0; miss_en = 1'b0; flush = 1'b0;

`ifdef REPLACE_RANDOM_EN
    rst = 1'b0;
    model_reset();
    tick();
    rst       = 1'b1;
    rand_mode = 1'b1;
    miss_en   = 1'b1;
    expect_way("rand_seed", 9, 1);
    tick();
    expect_way("rand_step1", 9, 3);
    for (int i = 0; i < 20; i++) begin
      miss_index = 8'($urandom_range(0, 255));
      tick();
    end
    miss_en   = 1'b0;
    rand_mode = 1'b0;
    tick();
`endif

    tick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
